// File: rtl/menu_select_controller_if.sv
// Command handshake between the menu controller and the game FSM.
// The controller drives the command code and valid; the consumer drives ready.
interface menu_select_controller_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;

  // Controller side: offers a command and waits for acceptance.
  modport master (
    output cmd_valid,
    output cmd,
    input  cmd_ready
  );

  // Game FSM side: observes the command and accepts it.
  modport slave (
    input  cmd_valid,
    input  cmd,
    output cmd_ready
  );
endinterface

// File: rtl/menu_select_controller.sv
// Menu button sequencer.
// - Keeps the highlighted button index, with wrap-around stepping and held-key
//   auto-repeat timed in video frames.
// - Drives a one-hot highlight for the button sprites.
// - Issues the confirmed button index as a command over a valid/ready handshake.
//   A single press of confirm produces exactly one command.
module menu_select_controller #(
  parameter  int NUM_BUTTONS  = 4,
  parameter  int REPEAT_DELAY = 30,
  parameter  int REPEAT_RATE  = 6,
  localparam int IDXW         = $clog2(NUM_BUTTONS)
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   enable_in,
  input  logic                   new_frame_in,
  input  logic                   up_in,
  input  logic                   down_in,
  input  logic                   confirm_in,
  output logic [NUM_BUTTONS-1:0] selected_out,
  output logic [IDXW-1:0]        sel_idx_out,
  menu_select_controller_if.master cmd_bus
);

  // The frame counter must hold the larger of the two repeat periods.
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNTW    = $clog2(CNT_MAX + 1);

  localparam logic [CNTW-1:0] DELAY_LAST = CNTW'(REPEAT_DELAY - 1);
  localparam logic [CNTW-1:0] RATE_LAST  = CNTW'(REPEAT_RATE - 1);
  localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(NUM_BUTTONS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT,
    ST_CONFIRM,
    ST_RELEASE
  } state_t;

  state_t                 state_reg, state_next;
  logic [IDXW-1:0]        idx_reg, idx_next;
  logic [NUM_BUTTONS-1:0] sel_reg, sel_next;
  logic [CNTW-1:0]        cnt_reg, cnt_next;
  logic                   dir_down_reg, dir_down_next;
  logic                   cmd_valid_reg, cmd_valid_next;
  logic [1:0]             cmd_reg, cmd_next;

  logic up_q_reg, down_q_reg, confirm_q_reg;

  logic       rise_confirm;
  logic       up_level, down_level;
  logic       up_edge, down_edge;
  logic       held_active;
  logic       step_req;
  logic       step_down;
  logic [1:0] idx_cmd;

  // Wrap-around step of the highlight: down moves forward, up moves back.
  function automatic logic [IDXW-1:0] step_idx(input logic [IDXW-1:0] idx,
                                               input logic            go_down);
    logic [IDXW-1:0] res;
    if (go_down) begin
      res = (idx == IDX_LAST) ? '0 : idx + IDXW'(1);
    end else begin
      res = (idx == '0) ? IDX_LAST : idx - IDXW'(1);
    end
    return res;
  endfunction

  // A direction is only valid when exactly one of up/down is pressed.
  assign up_level     = up_in & ~down_in;
  assign down_level   = down_in & ~up_in;
  assign up_edge      = up_in & ~up_q_reg & ~down_in;
  assign down_edge    = down_in & ~down_q_reg & ~up_in;
  assign rise_confirm = confirm_in & ~confirm_q_reg;
  assign held_active  = dir_down_reg ? down_level : up_level;

  // Command code is the low two bits of the index, zero-extended for tiny menus.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cmd_bits
      if (gi < IDXW) begin : g_from_idx
        assign idx_cmd[gi] = idx_reg[gi];
      end else begin : g_zero
        assign idx_cmd[gi] = 1'b0;
      end
    end
  endgenerate

  // One-hot highlight computed from the next index so it registers alongside it.
  generate
    for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_onehot
      assign sel_next[gi] = (idx_next == IDXW'(gi));
    end
  endgenerate

  // Input history for edge detection, sampled every cycle even when disabled.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      up_q_reg      <= 1'b0;
      down_q_reg    <= 1'b0;
      confirm_q_reg <= 1'b0;
    end else begin
      up_q_reg      <= up_in;
      down_q_reg    <= down_in;
      confirm_q_reg <= confirm_in;
    end
  end

  // Controller state, highlight, repeat counter and pending command.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      sel_reg       <= NUM_BUTTONS'(1);
      cnt_reg       <= '0;
      dir_down_reg  <= 1'b0;
      cmd_valid_reg <= 1'b0;
      cmd_reg       <= 2'b00;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      sel_reg       <= sel_next;
      cnt_reg       <= cnt_next;
      dir_down_reg  <= dir_down_next;
      cmd_valid_reg <= cmd_valid_next;
      cmd_reg       <= cmd_next;
    end
  end

  // Next-state logic: navigation, auto-repeat timing and command handshake.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    dir_down_next  = dir_down_reg;
    cmd_valid_next = cmd_valid_reg;
    cmd_next       = cmd_reg;
    step_req       = 1'b0;
    step_down      = dir_down_reg;

    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (enable_in) begin
          // Confirm wins over a direction edge in the same cycle.
          if (rise_confirm) begin
            state_next     = ST_CONFIRM;
            cmd_next       = idx_cmd;
            cmd_valid_next = 1'b1;
          end else if (up_edge || down_edge) begin
            state_next    = ST_HOLD;
            step_req      = 1'b1;
            step_down     = down_edge;
            dir_down_next = down_edge;
          end
        end
      end

      ST_HOLD, ST_REPEAT: begin
        if (!enable_in) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (rise_confirm) begin
          state_next     = ST_CONFIRM;
          cnt_next       = '0;
          cmd_next       = idx_cmd;
          cmd_valid_next = 1'b1;
        end else if (up_edge || down_edge) begin
          // Switching direction without a both-high gap restarts the hold.
          state_next    = ST_HOLD;
          cnt_next      = '0;
          step_req      = 1'b1;
          step_down     = down_edge;
          dir_down_next = down_edge;
        end else if (!held_active) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (new_frame_in) begin
          if (cnt_reg == ((state_reg == ST_HOLD) ? DELAY_LAST : RATE_LAST)) begin
            state_next = ST_REPEAT;
            cnt_next   = '0;
            step_req   = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNTW'(1);
          end
        end
      end

      ST_CONFIRM: begin
        // Command stays on the bus until taken, regardless of enable.
        cnt_next = '0;
        if (cmd_valid_reg && cmd_bus.cmd_ready) begin
          cmd_valid_next = 1'b0;
          state_next     = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        cnt_next = '0;
        if (!confirm_in) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next     = ST_IDLE;
        cnt_next       = '0;
        cmd_valid_next = 1'b0;
      end
    endcase

    idx_next = step_req ? step_idx(idx_reg, step_down) : idx_reg;
  end

  assign selected_out      = sel_reg;
  assign sel_idx_out       = idx_reg;
  assign cmd_bus.cmd_valid = cmd_valid_reg;
  assign cmd_bus.cmd       = cmd_reg;

endmodule

// File: tb/tb_menu_select_controller.sv
// Directed bench for the menu select controller: navigation, wrap, auto-repeat,
// command handshake, disable behaviour and asynchronous reset.
`timescale 1ns/1ps
module tb_menu_select_controller;

  localparam int NUM_BUTTONS = 4;
  localparam int IDXW        = 2;

  logic                   clk_in;
  logic                   rst_n_in;
  logic                   enable_in;
  logic                   new_frame_in;
  logic                   up_in;
  logic                   down_in;
  logic                   confirm_in;
  logic [NUM_BUTTONS-1:0] selected_out;
  logic [IDXW-1:0]        sel_idx_out;

  int tests_run;
  int tests_failed;

  menu_select_controller_if cmd_if ();

  menu_select_controller #(
    .NUM_BUTTONS (NUM_BUTTONS),
    .REPEAT_DELAY(30),
    .REPEAT_RATE (6)
  ) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .enable_in   (enable_in),
    .new_frame_in(new_frame_in),
    .up_in       (up_in),
    .down_in     (down_in),
    .confirm_in  (confirm_in),
    .selected_out(selected_out),
    .sel_idx_out (sel_idx_out),
    .cmd_bus     (cmd_if.master)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Count a comparison and report it if it does not match.
  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0d", tag, got);
    end
  endtask

  // Advance n clocks; inputs change and outputs are sampled 1ns after the edge.
  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic frame_pulse();
    new_frame_in = 1'b1;
    cycle(1);
    new_frame_in = 1'b0;
    cycle(1);
  endtask

  task automatic press_down();
    down_in = 1'b1;
    cycle(1);
    down_in = 1'b0;
    cycle(1);
  endtask

  task automatic press_up();
    up_in = 1'b1;
    cycle(1);
    up_in = 1'b0;
    cycle(1);
  endtask

  task automatic check_sel(input string tag, input int exp_idx);
    check_value({tag, "_idx"}, 32'(sel_idx_out), 32'(exp_idx));
    check_value({tag, "_sel"}, 32'(selected_out), 32'(1) << exp_idx);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n_in     = 1'b0;
    enable_in    = 1'b0;
    new_frame_in = 1'b0;
    up_in        = 1'b0;
    down_in      = 1'b0;
    confirm_in   = 1'b0;
    cmd_if.cmd_ready = 1'b0;

    // Reset state.
    cycle(3);
    check_sel("reset", 0);
    check_value("reset_valid", 32'(cmd_if.cmd_valid), 32'd0);
    check_value("reset_cmd", 32'(cmd_if.cmd), 32'd0);
    rst_n_in  = 1'b1;
    enable_in = 1'b1;
    cycle(2);

    // Three down presses walk the highlight 1, 2, 3.
    for (int i = 1; i <= 3; i++) begin
      down_in = 1'b1;
      cycle(1);
      check_sel($sformatf("down%0d", i), i);
      down_in = 1'b0;
      cycle(1);
    end

    // Wrap in both directions, both-high is not a direction.
    press_down();
    check_sel("wrap_down", 0);
    press_up();
    check_sel("wrap_up", 3);
    up_in   = 1'b1;
    down_in = 1'b1;
    cycle(3);
    check_sel("both_high", 3);
    up_in   = 1'b0;
    down_in = 1'b0;
    cycle(2);
    check_sel("both_released", 3);

    // Held down: step at edge, after 30 frames, then every 6 frames.
    down_in = 1'b1;
    cycle(1);
    check_sel("hold_edge", 0);
    for (int f = 1; f <= 29; f++) frame_pulse();
    check_sel("hold_f29", 0);
    frame_pulse();
    check_sel("hold_f30", 1);
    for (int f = 31; f <= 35; f++) frame_pulse();
    check_sel("hold_f35", 1);
    frame_pulse();
    check_sel("hold_f36", 2);
    for (int f = 37; f <= 42; f++) frame_pulse();
    check_sel("hold_f42", 3);
    down_in = 1'b0;
    cycle(2);
    frame_pulse();
    check_sel("hold_released", 3);

    // Direction change while held restarts the hold with a single step.
    down_in = 1'b1;
    cycle(1);
    check_sel("chg_down", 0);
    down_in = 1'b0;
    up_in   = 1'b1;
    cycle(1);
    check_sel("chg_up", 3);
    for (int f = 1; f <= 29; f++) frame_pulse();
    check_sel("chg_f29", 3);
    frame_pulse();
    check_sel("chg_f30", 2);
    up_in = 1'b0;
    cycle(2);

    // Confirm with consumer stalled, then accepted; held confirm gives no second command.
    confirm_in = 1'b1;
    cycle(1);
    check_value("cfm_valid", 32'(cmd_if.cmd_valid), 32'd1);
    check_value("cfm_cmd", 32'(cmd_if.cmd), 32'd2);
    down_in = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cycle(1);
      check_value($sformatf("cfm_stall%0d_valid", c), 32'(cmd_if.cmd_valid), 32'd1);
      check_value($sformatf("cfm_stall%0d_cmd", c), 32'(cmd_if.cmd), 32'd2);
    end
    check_sel("cfm_nav_ignored", 2);
    down_in = 1'b0;
    cmd_if.cmd_ready = 1'b1;
    cycle(1);
    check_value("cfm_accepted", 32'(cmd_if.cmd_valid), 32'd0);
    cycle(8);
    check_value("cfm_held_no_second", 32'(cmd_if.cmd_valid), 32'd0);
    confirm_in = 1'b0;
    cycle(2);
    check_value("cfm_released", 32'(cmd_if.cmd_valid), 32'd0);
    cmd_if.cmd_ready = 1'b0;

    // Disabled: holding up over 50 frames does nothing.
    enable_in = 1'b0;
    cycle(1);
    up_in = 1'b1;
    for (int f = 0; f < 50; f++) frame_pulse();
    check_sel("dis_hold", 2);
    check_value("dis_valid", 32'(cmd_if.cmd_valid), 32'd0);
    // Re-enabling with up already held must not step (no fresh edge from IDLE).
    enable_in = 1'b1;
    for (int f = 0; f < 35; f++) frame_pulse();
    check_sel("reen_held", 2);
    up_in = 1'b0;
    cycle(2);

    // Asynchronous reset during CONFIRM.
    confirm_in = 1'b1;
    cycle(1);
    check_value("rst_cfm_pre_valid", 32'(cmd_if.cmd_valid), 32'd1);
    #2;
    rst_n_in = 1'b0;
    #1;
    check_value("rst_cfm_valid", 32'(cmd_if.cmd_valid), 32'd0);
    check_value("rst_cfm_cmd", 32'(cmd_if.cmd), 32'd0);
    check_sel("rst_cfm", 0);
    confirm_in = 1'b0;
    cycle(2);
    rst_n_in = 1'b1;
    cycle(2);

    // Asynchronous reset during REPEAT.
    down_in = 1'b1;
    cycle(1);
    for (int f = 0; f < 30; f++) frame_pulse();
    check_sel("rst_rep_pre", 2);
    #2;
    rst_n_in = 1'b0;
    #1;
    check_sel("rst_rep", 0);
    check_value("rst_rep_valid", 32'(cmd_if.cmd_valid), 32'd0);
    down_in = 1'b0;
    cycle(2);
    rst_n_in = 1'b1;
    cycle(2);
    check_sel("rst_rep_after", 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
